// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - round-robin writeback arbiter from execute pipes to register file and commit.
// Optional macro WRITEBACK_ARBITER_X0_FILTER_EN suppresses register-file writes to x0.
module writeback_arbiter #(
  parameter int p_num_pipes    = 2,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0]                X_val,
  output logic [p_num_pipes-1:0]                X_rdy,
  input  logic [32*p_num_pipes-1:0]             X_pc,
  input  logic [p_seq_num_bits*p_num_pipes-1:0] X_seq_num,
  input  logic [5*p_num_pipes-1:0]              X_waddr,
  input  logic [32*p_num_pipes-1:0]             X_wdata,
  input  logic [p_num_pipes-1:0]                X_wen,
  output logic [4:0]                            rf_waddr,
  output logic [31:0]                           rf_wdata,
  output logic                                  rf_wen,
  output logic                                  commit_val,
  output logic [31:0]                           commit_pc,
  output logic [p_seq_num_bits-1:0]             commit_seq_num,
  output logic [31:0]                           insn_count
);

  localparam int ptr_bits = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  logic [ptr_bits-1:0]       ptr;
  logic [ptr_bits-1:0]       ptr_nxt;
  logic [ptr_bits-1:0]       grant_idx;
  logic                      grant_any;
  int                        idx;

  logic                      out_val;
  logic [31:0]               out_pc;
  logic [p_seq_num_bits-1:0] out_seq_num;
  logic [4:0]                out_waddr;
  logic [31:0]               out_wdata;
  logic                      out_wen;
  logic [31:0]               insn_count_q;

  // Scan pipes starting at ptr; the first valid one wins. Nothing is granted in reset.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (rst) begin
      for (int k = 0; k < p_num_pipes; k++) begin
        idx = int'(ptr) + k;
        if (idx >= p_num_pipes) idx = idx - p_num_pipes;
        if (!grant_any && X_val[idx]) begin
          grant_any = 1'b1;
          grant_idx = ptr_bits'(idx);
        end
      end
    end
  end

  always_comb begin
    X_rdy = '0;
    if (grant_any) X_rdy[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_nxt = ptr;
    if (grant_any) begin
      if (grant_idx == ptr_bits'(p_num_pipes - 1)) ptr_nxt = '0;
      else                                         ptr_nxt = grant_idx + 1'b1;
    end
  end

  // Reset wins over a pending entry: it is dropped without being written or counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_val      <= 1'b0;
      ptr          <= '0;
      insn_count_q <= '0;
    end else begin
      out_val <= grant_any;
      ptr     <= ptr_nxt;
      if (grant_any) begin
        out_pc      <= X_pc[32*int'(grant_idx) +: 32];
        out_seq_num <= X_seq_num[p_seq_num_bits*int'(grant_idx) +: p_seq_num_bits];
        out_waddr   <= X_waddr[5*int'(grant_idx) +: 5];
        out_wdata   <= X_wdata[32*int'(grant_idx) +: 32];
        out_wen     <= X_wen[grant_idx];
      end
      if (out_val) insn_count_q <= insn_count_q + 32'd1;
    end
  end

  assign commit_val     = out_val;
  assign commit_pc      = out_pc;
  assign commit_seq_num = out_seq_num;
  assign rf_waddr       = out_waddr;
  assign rf_wdata       = out_wdata;
  assign insn_count     = insn_count_q;

`ifdef WRITEBACK_ARBITER_X0_FILTER_EN
  assign rf_wen = out_val & out_wen & (out_waddr != 5'd0);
`else
  assign rf_wen = out_val & out_wen;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter with a queue-based reference model.
module tb_writeback_arbiter;

  localparam int NP = 2;
  localparam int SB = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP-1:0]     X_val = '0;
  logic [NP-1:0]     X_rdy;
  logic [32*NP-1:0]  X_pc;
  logic [SB*NP-1:0]  X_seq_num;
  logic [5*NP-1:0]   X_waddr;
  logic [32*NP-1:0]  X_wdata;
  logic [NP-1:0]     X_wen;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              rf_wen;
  logic              commit_val;
  logic [31:0]       commit_pc;
  logic [SB-1:0]     commit_seq_num;
  logic [31:0]       insn_count;

  logic [31:0]       pc_a    [NP];
  logic [SB-1:0]     seq_a   [NP];
  logic [4:0]        waddr_a [NP];
  logic [31:0]       wdata_a [NP];
  logic              wen_a   [NP];

  typedef struct {
    logic [31:0]   pc;
    logic [SB-1:0] seq;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic          wen;
  } exp_t;

  exp_t        exp_q[$];
  int          mptr = 0;
  logic [31:0] exp_count = 32'd0;
  int          total = 0;
  int          bad = 0;

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign X_pc[32*g +: 32]      = pc_a[g];
    assign X_seq_num[SB*g +: SB] = seq_a[g];
    assign X_waddr[5*g +: 5]     = waddr_a[g];
    assign X_wdata[32*g +: 32]   = wdata_a[g];
    assign X_wen[g]              = wen_a[g];
  end

  writeback_arbiter #(.p_num_pipes(NP), .p_seq_num_bits(SB)) dut (
    .clk(clk), .rst(rst),
    .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_seq_num(X_seq_num),
    .X_waddr(X_waddr), .X_wdata(X_wdata), .X_wen(X_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .commit_val(commit_val), .commit_pc(commit_pc), .commit_seq_num(commit_seq_num),
    .insn_count(insn_count)
  );

  always #5 clk = ~clk;

  task automatic rand_payload();
    for (int p = 0; p < NP; p++) begin
      pc_a[p]    = $urandom;
      seq_a[p]   = SB'($urandom);
      waddr_a[p] = 5'($urandom_range(0, 31));
      wdata_a[p] = $urandom;
      wen_a[p]   = 1'($urandom_range(0, 1));
    end
  endtask

  // Called at posedge+1; drives one cycle, checks grant at negedge, returns at next posedge+1.
  task automatic step(input logic [NP-1:0] val, input logic r);
    int          g;
    logic [NP-1:0] er;
    exp_t        e;
    rst   = r;
    X_val = val;
    @(negedge clk);
    g  = -1;
    er = '0;
    if (r) begin
      for (int k = 0; k < NP; k++) begin
        if (g < 0 && val[(mptr + k) % NP]) g = (mptr + k) % NP;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    total++;
    if (X_rdy !== er) begin
      bad++;
      $display("FAIL x_rdy got=%b exp=%b val=%b", X_rdy, er, val);
    end
    if (g >= 0) begin
      e.pc = pc_a[g]; e.seq = seq_a[g]; e.waddr = waddr_a[g];
      e.wdata = wdata_a[g]; e.wen = wen_a[g];
      exp_q.push_back(e);
      mptr = (g + 1) % NP;
    end
    if (!r) mptr = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input int p, input logic [31:0] pc, input logic [4:0] wa,
                          input logic [31:0] wd, input logic we);
    pc_a[p] = pc; seq_a[p] = SB'(p + 1); waddr_a[p] = wa; wdata_a[p] = wd; wen_a[p] = we;
  endtask

  // Monitor: compares every commit against the scoreboard and tracks the expected count.
  initial begin
    exp_t e;
    logic ewen;
    @(posedge clk);
    forever begin
      @(negedge clk);
      total++;
      if (insn_count !== exp_count) begin
        bad++;
        $display("FAIL insn_count got=%h exp=%h", insn_count, exp_count);
      end
      if (commit_val) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_commit pc=%h", commit_pc);
        end else begin
          e = exp_q.pop_front();
`ifdef WRITEBACK_ARBITER_X0_FILTER_EN
          ewen = e.wen && (e.waddr != 5'd0);
`else
          ewen = e.wen;
`endif
          if ({commit_pc, commit_seq_num, rf_waddr, rf_wdata, rf_wen} !==
              {e.pc, e.seq, e.waddr, e.wdata, ewen}) begin
            bad++;
            $display("FAIL commit got pc=%h seq=%h wa=%0d wd=%h wen=%b exp pc=%h seq=%h wa=%0d wd=%h wen=%b",
                     commit_pc, commit_seq_num, rf_waddr, rf_wdata, rf_wen,
                     e.pc, e.seq, e.waddr, e.wdata, ewen);
          end
        end
      end else begin
        total++;
        if (rf_wen !== 1'b0) begin
          bad++;
          $display("FAIL idle_rf_wen got=%b exp=0", rf_wen);
        end
      end
      if (!rst)           exp_count = 32'd0;
      else if (commit_val) exp_count = exp_count + 32'd1;
    end
  end

  initial begin
    rand_payload();
    #1;
    // Reset held with every pipe requesting.
    step('1, 1'b0);
    step('1, 1'b0);

    // Single pipe directed transfer.
    set_pipe(0, 32'h200, 5'd3, 32'hDEADBEEF, 1'b1);
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);

    // Round-robin from a fresh reset: 0,1,0,1.
    step(2'b00, 1'b0);
    for (int c = 0; c < 4; c++) begin
      set_pipe(0, 32'h1000 + c, 5'd5, 32'hA0 + c, 1'b1);
      set_pipe(1, 32'h2000 + c, 5'd6, 32'hB0 + c, 1'b1);
      step(2'b11, 1'b1);
    end
    step(2'b00, 1'b1);

    // Write to x0.
    set_pipe(1, 32'h300, 5'd0, 32'h12345678, 1'b1);
    step(2'b10, 1'b1);
    step(2'b00, 1'b1);

    // Single pipe full throughput.
    for (int c = 0; c < 6; c++) begin
      rand_payload();
      step(2'b10, 1'b1);
    end
    step(2'b00, 1'b1);

    // Counter wrap.
    force dut.insn_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.insn_count_q;
    exp_count = 32'hFFFF_FFFF;
    step(2'b00, 1'b1);
    set_pipe(0, 32'h400, 5'd7, 32'h77, 1'b1);
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);

    // Reset arriving while an entry sits in the output register.
    set_pipe(0, 32'h500, 5'd9, 32'h99, 1'b1);
    step(2'b01, 1'b1);
    step(2'b01, 1'b0);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 300; c++) begin
      rand_payload();
      step(NP'($urandom), ($urandom_range(0, 39) != 0));
    end
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Param p_num_pipes, default 2, number of execute pipes feeding writeback (legal 1..8).
REQ-002 Param p_seq_num_bits, default 5, width of instruction sequence numbers.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous, active-low reset (0 = reset asserted, sampled at posedge clk).
REQ-005 X_val  in  p_num_pipes  per-pipe result valid.
REQ-006 X_rdy  out  p_num_pipes  per-pipe accept; transfer on pipe i when X_val[i] & X_rdy[i].
REQ-007 X_pc  in  32*p_num_pipes  per-pipe instruction PC; pipe i at bits [32i+31:32i].
REQ-008 X_seq_num  in  p_seq_num_bits*p_num_pipes  per-pipe sequence number.
REQ-009 X_waddr  in  5*p_num_pipes  per-pipe destination register.
REQ-010 X_wdata  in  32*p_num_pipes  per-pipe result data.
REQ-011 X_wen  in  p_num_pipes  per-pipe register-write request.
REQ-012 rf_waddr  out  5  register-file write address.
REQ-013 rf_wdata  out  32  register-file write data.
REQ-014 rf_wen  out  1  register-file write enable.
REQ-015 commit_val  out  1  one instruction completed this cycle.
REQ-016 commit_pc  out  32; commit_seq_num  out  p_seq_num_bits; completed instruction identity.
REQ-017 insn_count  out  32  running count of completed instructions.

Function
REQ-018 Block SHALL accept at most one pipe per cycle; X_rdy is one-hot or zero.
REQ-019 X_rdy[i] SHALL be 1 iff X_val[i]=1 and i is the first valid pipe found scanning i=ptr, ptr+1, ... mod p_num_pipes; combinational in X_val and ptr.
REQ-020 ptr (clog2(p_num_pipes) bits, min 1) SHALL become (g+1) mod p_num_pipes after a transfer from pipe g; unchanged when no transfer.
REQ-021 On transfer from pipe g, output register SHALL capture pipe g's pc, seq_num, waddr, wdata, wen and set out_val=1 at next posedge (latency exactly 1 cycle).
REQ-022 With no transfer in a cycle, out_val SHALL be 0 next cycle; no downstream backpressure, entry held one cycle only.
REQ-023 commit_val=out_val; commit_pc, commit_seq_num, rf_waddr, rf_wdata SHALL reflect the output register.
REQ-024 rf_wen SHALL equal out_val & out_wen (further qualified per REQ-031).
REQ-025 insn_count SHALL increment by 1 at each posedge where out_val=1; wraps 0xFFFFFFFF -> 0x00000000.
REQ-026 Single valid pipe SHALL be granted every cycle it is valid (full throughput, no bubbles).
REQ-027 All pipes valid continuously SHALL be granted strictly round-robin: ptr, ptr+1, ...

Reset
REQ-028 While rst=0, X_rdy SHALL be all 0 and no transfer SHALL occur.
REQ-029 At posedge with rst=0: out_val<=0, ptr<=0, insn_count<=0; hence rf_wen=0, commit_val=0 in the following cycle.
REQ-030 Reset asserted while out_val=1 SHALL discard that entry (no write, no count).

Configuration
REQ-031 Macro WRITEBACK_ARBITER_X0_FILTER_EN: defined -> rf_wen forced 0 when rf_waddr=0 (commit_val and insn_count unaffected); undefined -> rf_wen per REQ-024 regardless of address.

Verification
REQ-032 Reset: rst=0 two cycles with all X_val=1 -> X_rdy=0, rf_wen=0, commit_val=0, insn_count=0.
REQ-033 Single pipe: pipe 0 valid pc=0x200, waddr=3, wdata=0xDEADBEEF, wen=1 -> X_rdy[0]=1 same cycle; next cycle rf_wen=1, rf_waddr=3, rf_wdata=0xDEADBEEF, commit_pc=0x200, insn_count 0->1 following edge.
REQ-034 Round-robin: p_num_pipes=2, both valid 4 cycles from reset -> grants 0,1,0,1; commits in that order.
REQ-035 x0 write: waddr=0, wen=1 -> rf_wen=1 without macro, rf_wen=0 with WRITEBACK_ARBITER_X0_FILTER_EN; commit_val=1 both builds.
REQ-036 Wrap: force insn_count=0xFFFFFFFF, one commit -> insn_count=0x00000000.
REQ-037 Reset mid-op: transfer at cycle N, rst=0 at edge N+1 -> no commit visible after reset, insn_count=0.
